// File: rtl/dual_port_mem_ctrl_pkg.sv
// Shared definitions for the dual-port data memory controller.
// Holds the default bus widths, the controller state encoding and the
// helper that decides whether an address falls inside the I/O window.
package mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // True when addr lies in [base, base+num).
  function automatic logic in_io_window(input int unsigned addr,
                                        input int unsigned base,
                                        input int unsigned num);
    return (addr >= base) && (addr < base + num);
  endfunction

endpackage

// File: rtl/dual_port_mem_ctrl_if.sv
// Bus bundle between the CPU/requester side and the memory controller.
// Port A: a_we, a_addr, a_din in; a_dout, a_stall out.
// Port B: b_req, b_we, b_addr, b_din in; b_dout, b_ack out.
// master = CPU/requester view, slave = memory controller view.
interface dual_port_mem_ctrl_if #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W
);

  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [DATA_W-1:0] a_dout;
  logic              a_stall;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic [DATA_W-1:0] b_dout;
  logic              b_ack;

  modport master (
    output a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
    input  a_dout, a_stall, b_dout, b_ack
  );

  modport slave (
    input  a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
    output a_dout, a_stall, b_dout, b_ack
  );

endinterface

// File: rtl/dual_port_mem_ctrl_dp_ram_core.sv
// Plain dual-port synchronous RAM, no reset on contents or outputs.
// Both ports are write-first: a write returns its own data on dout.
// Ports: clk; a_we/a_addr/a_din -> a_dout; b_we/b_addr/b_din -> b_dout.
// The caller guarantees the two ports never write the same address in
// the same cycle; if they did, port A's write would land last.
module dp_ram_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both ports share one process so the array has a single writer.
  // A read on one port sees the pre-edge contents even when the other
  // port writes the same word this cycle.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
    if (a_we) mem[a_addr] <= a_din;
    a_dout <= a_we ? a_din : mem[a_addr];
    b_dout <= b_we ? b_din : mem[b_addr];
  end

endmodule

// File: rtl/dual_port_mem_ctrl.sv
// Dual-port data memory controller: CPU port A with a memory-mapped I/O
// window, requester port B with req/ack handshake, post-reset clear
// sequencer and same-address arbitration where a port A write wins.
// Ports: clk, reset (async, active high); bus (slave modport, ports A/B);
// io_in/io_out (NUM_IO words mapped at IO_BASE on port A only);
// ready (clear finished, memory usable).
module dual_port_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int IO_BASE        = 1020,
  parameter int NUM_IO         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  dual_port_mem_ctrl_if.slave      bus,
  input  logic [NUM_IO*DATA_W-1:0] io_in,
  output logic [NUM_IO*DATA_W-1:0] io_out,
  output logic                     ready
);

  localparam int                DEPTH       = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST        = ADDR_W'(DEPTH - 1);
  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              a_stall_q;
  logic              run;
  logic              a_io;
  logic              b_io;
  logic              a_ram_wr;
  logic              b_blocked;
  logic              b_accept;
  logic [DATA_W-1:0] io_rd;

  logic              core_a_we;
  logic [ADDR_W-1:0] core_a_addr;
  logic [DATA_W-1:0] core_a_din;
  logic [DATA_W-1:0] core_a_dout;
  logic              core_b_we;
  logic [DATA_W-1:0] core_b_dout;

  logic              a_src_ram;
  logic [DATA_W-1:0] a_hold;
  logic              b_src_ram;
  logic [DATA_W-1:0] b_hold;
  logic              b_ack_q;

  assign run      = (state == ST_RUN);
  assign a_io     = in_io_window(32'(bus.a_addr), IO_BASE, NUM_IO);
  assign b_io     = in_io_window(32'(bus.b_addr), IO_BASE, NUM_IO);
  assign a_ram_wr = run && bus.a_we && !a_io;

  // A port A RAM write to the address port B wants blocks B for this
  // cycle; B simply retries next cycle while b_req stays high.
  assign b_blocked = a_ram_wr && (bus.b_addr == bus.a_addr);
  assign b_accept  = run && bus.b_req && !b_blocked;
  assign core_b_we = b_accept && bus.b_we && !b_io;

  // Clear sequencer: one zero write per cycle walking cnt over the whole
  // array, then hand the memory over to the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      ready     <= !CLEAR_ON_RESET;
      a_stall_q <= CLEAR_ON_RESET;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= ST_RUN;
        ready     <= 1'b1;
        a_stall_q <= 1'b0;
      end
    end
  end

  // The clear sequencer borrows RAM port A while clearing; otherwise
  // port A goes straight through, with I/O-window writes kept off the RAM.
  always_comb begin
    core_a_we   = a_ram_wr;
    core_a_addr = bus.a_addr;
    core_a_din  = bus.a_din;
    if (state == ST_CLEAR) begin
      core_a_we   = 1'b1;
      core_a_addr = cnt;
      core_a_din  = '0;
    end
  end

  // Select the I/O input word addressed by port A.
  always_comb begin
    io_rd = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (bus.a_addr == ADDR_W'(IO_BASE + i)) io_rd = io_in[i*DATA_W +: DATA_W];
    end
  end

  dp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .a_we   (core_a_we),
    .a_addr (core_a_addr),
    .a_din  (core_a_din),
    .a_dout (core_a_dout),
    .b_we   (core_b_we),
    .b_addr (bus.b_addr),
    .b_din  (bus.b_din),
    .b_dout (core_b_dout)
  );

  // Port A result steering. RAM results come straight from the core's
  // output register; I/O results, and the held value while clearing,
  // live in a_hold so a_dout freezes when the core port is borrowed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_src_ram <= 1'b0;
      a_hold    <= '0;
      io_out    <= '0;
    end else if (!run) begin
      a_src_ram <= 1'b0;
      a_hold    <= bus.a_dout;
    end else if (a_io) begin
      a_src_ram <= 1'b0;
      if (bus.a_we) begin
        a_hold <= bus.a_din;
        for (int i = 0; i < NUM_IO; i++) begin
          if (bus.a_addr == ADDR_W'(IO_BASE + i)) io_out[i*DATA_W +: DATA_W] <= bus.a_din;
        end
      end else begin
        a_hold <= io_rd;
      end
    end else begin
      a_src_ram <= 1'b1;
    end
  end

  // Port B handshake and result steering. b_dout shows the core output
  // only in the ack cycle of a RAM access and is frozen in b_hold
  // otherwise; the I/O window reads as zero from this side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_ack_q   <= 1'b0;
      b_src_ram <= 1'b0;
      b_hold    <= '0;
    end else begin
      b_ack_q <= b_accept;
      if (b_accept && !b_io) begin
        b_src_ram <= 1'b1;
      end else begin
        b_src_ram <= 1'b0;
        b_hold    <= b_accept ? '0 : bus.b_dout;
      end
    end
  end

  assign bus.a_dout  = a_src_ram ? core_a_dout : a_hold;
  assign bus.a_stall = a_stall_q;
  assign bus.b_dout  = b_src_ram ? core_b_dout : b_hold;
  assign bus.b_ack   = b_ack_q;

endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Testbench for dual_port_mem_ctrl with default parameters
// (16-bit data, 1024 words, I/O window at 1020..1023, clear on reset).
// Stimulus pushes expected port results into queues; two monitors pop
// and compare whenever port A completes an access or port B acks.
module tb_dual_port_mem_ctrl;

  typedef struct {
    bit          rd;
    logic [15:0] data;
  } b_exp_t;

  logic        clk;
  logic        reset;
  logic [63:0] io_in;
  logic [63:0] io_out;
  logic        ready;
  logic        a_vld;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_q[$];
  b_exp_t      b_q[$];

  dual_port_mem_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  dual_port_mem_ctrl #(
    .DATA_W         (16),
    .ADDR_W         (10),
    .IO_BASE        (1020),
    .NUM_IO         (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_in  (io_in),
    .io_out (io_out),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One port A access in the next cycle; expected a_dout is queued.
  task automatic applyStimulus(input logic we, input logic [9:0] addr,
                               input logic [15:0] din, input logic [15:0] exp);
    @(negedge clk);
    a_vld      = 1'b1;
    bus.a_we   = we;
    bus.a_addr = addr;
    bus.a_din  = din;
    a_q.push_back(exp);
  endtask

  task automatic aIdle();
    @(negedge clk);
    a_vld    = 1'b0;
    bus.a_we = 1'b0;
  endtask

  // One port B request held until ack; lat counts edges until ack seen.
  task automatic bAccess(input logic we, input logic [9:0] addr, input logic [15:0] din,
                         input logic [15:0] exp, output int lat);
    b_exp_t e;
    @(negedge clk);
    e.rd   = !we;
    e.data = exp;
    b_q.push_back(e);
    bus.b_req  = 1'b1;
    bus.b_we   = we;
    bus.b_addr = addr;
    bus.b_din  = din;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.b_ack && lat < 20);
    @(negedge clk);
    bus.b_req = 1'b0;
    bus.b_we  = 1'b0;
  endtask

  task automatic waitReady(output int n, output int acks);
    n    = 0;
    acks = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus.b_ack) acks++;
    end while (!ready && n < 1200);
  endtask

  // Port A monitor: an access issued in a non-stalled cycle shows its
  // result just after the closing edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      if (a_vld && !bus.a_stall) begin
        #1;
        if (a_q.size() == 0) begin
          checkOutput("a_unexpected_result", 64'(bus.a_dout), 64'hDEAD_0000);
        end else begin
          e = a_q.pop_front();
          checkOutput("a_dout", 64'(bus.a_dout), 64'(e));
        end
      end
    end
  end

  // Port B monitor: every ack consumes one expected entry; reads compare data.
  initial begin
    b_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.b_ack) begin
        if (b_q.size() == 0) begin
          checkOutput("b_unexpected_ack", 64'(bus.b_ack), 64'd0);
        end else begin
          e = b_q.pop_front();
          if (e.rd) checkOutput("b_dout", 64'(bus.b_dout), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int lat;
    int n;
    int acks;
    reset      = 1'b1;
    a_vld      = 1'b0;
    io_in      = '0;
    bus.a_we   = 1'b0;
    bus.a_addr = '0;
    bus.a_din  = '0;
    bus.b_req  = 1'b0;
    bus.b_we   = 1'b0;
    bus.b_addr = '0;
    bus.b_din  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_a_stall", 64'(bus.a_stall), 64'd1);
    checkOutput("rst_a_dout", 64'(bus.a_dout), 64'd0);
    checkOutput("rst_b_dout", 64'(bus.b_dout), 64'd0);
    checkOutput("rst_b_ack", 64'(bus.b_ack), 64'd0);
    checkOutput("rst_io_out", io_out, 64'd0);

    reset = 1'b0;
    waitReady(n, acks);
    checkOutput("clear_cycles", 64'(n), 64'd1024);
    checkOutput("a_stall_after_clear", 64'(bus.a_stall), 64'd0);

    applyStimulus(1'b0, 10'd0, 16'd0, 16'd0);
    applyStimulus(1'b0, 10'd511, 16'd0, 16'd0);
    applyStimulus(1'b1, 10'd5, 16'd233, 16'd233);
    applyStimulus(1'b0, 10'd5, 16'd0, 16'd233);
    aIdle();

    io_in = 64'h0000_1234_0000_0000;
    applyStimulus(1'b1, 10'd1021, 16'h00AA, 16'h00AA);
    applyStimulus(1'b0, 10'd1022, 16'd0, 16'h1234);
    aIdle();
    checkOutput("io_out_slice1", 64'(io_out[31:16]), 64'h00AA);
    checkOutput("io_out_slice0", 64'(io_out[15:0]), 64'd0);
    bAccess(1'b0, 10'd1021, 16'd0, 16'd0, lat);
    checkOutput("b_io_read_lat", 64'(lat), 64'd1);

    fork
      begin
        applyStimulus(1'b1, 10'd7, 16'd100, 16'd100);
        aIdle();
      end
      bAccess(1'b1, 10'd7, 16'd60, 16'd0, lat);
    join
    checkOutput("collision_lat", 64'(lat), 64'd2);
    applyStimulus(1'b0, 10'd7, 16'd0, 16'd60);
    aIdle();

    fork
      begin
        applyStimulus(1'b0, 10'd8, 16'd0, 16'd0);
        aIdle();
      end
      bAccess(1'b1, 10'd8, 16'h0BEE, 16'd0, lat);
    join
    checkOutput("a_rd_b_wr_lat", 64'(lat), 64'd1);
    fork
      begin
        applyStimulus(1'b0, 10'd8, 16'd0, 16'h0BEE);
        aIdle();
      end
      bAccess(1'b0, 10'd8, 16'd0, 16'h0BEE, lat);
    join
    checkOutput("rd_rd_lat", 64'(lat), 64'd1);

    @(negedge clk);
    b_q.push_back('{rd: 1'b0, data: 16'd0});
    bus.b_req  = 1'b1;
    bus.b_we   = 1'b1;
    bus.b_addr = 10'd300;
    bus.b_din  = 16'd987;
    @(posedge clk);
    #1;
    checkOutput("b2b_ack1", 64'(bus.b_ack), 64'd1);
    @(negedge clk);
    b_q.push_back('{rd: 1'b1, data: 16'd987});
    bus.b_we = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_ack2", 64'(bus.b_ack), 64'd1);
    @(negedge clk);
    bus.b_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b_ack_clears", 64'(bus.b_ack), 64'd0);
    checkOutput("b_dout_hold", 64'(bus.b_dout), 64'd987);

    fork
      begin
        applyStimulus(1'b1, 10'd400, 16'd50, 16'd50);
        aIdle();
      end
      begin
        @(negedge clk);
        bus.b_req  = 1'b1;
        bus.b_we   = 1'b1;
        bus.b_addr = 10'd400;
        bus.b_din  = 16'd77;
        @(negedge clk);
        bus.b_req = 1'b0;
        bus.b_we  = 1'b0;
      end
    join
    acks = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.b_ack) acks++;
    end
    checkOutput("drop_no_ack", 64'(acks), 64'd0);
    applyStimulus(1'b0, 10'd400, 16'd0, 16'd50);
    aIdle();

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("run_rst_ready", 64'(ready), 64'd0);
    checkOutput("run_rst_io_out", io_out, 64'd0);
    checkOutput("run_rst_a_stall", 64'(bus.a_stall), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_clear_rst_ready", 64'(ready), 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    bus.b_req  = 1'b1;
    bus.b_we   = 1'b0;
    bus.b_addr = 10'd9;
    waitReady(n, acks);
    checkOutput("restart_clear_cycles", 64'(n), 64'd1024);
    checkOutput("no_ack_during_clear", 64'(acks), 64'd0);
    @(negedge clk);
    bus.b_req = 1'b0;

    applyStimulus(1'b0, 10'd5, 16'd0, 16'd0);
    aIdle();
    bAccess(1'b0, 10'd300, 16'd0, 16'd0, lat);
    checkOutput("post_clear_b_lat", 64'(lat), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_queue_empty", 64'(a_q.size()), 64'd0);
    checkOutput("b_queue_empty", 64'(b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_port_mem_ctrl.md
Name: dual_port_mem_ctrl

Overview:
- Parametrised successor to the single-port behavioural RAM the CPU has used so far: synchronous dual-port data memory with a CPU port (A) and a requester port (B) for a program loader or display reader.
- Adds a post-reset clear sequencer, a memory-mapped I/O window on port A, and same-address collision arbitration between the ports.
- Sits between CPU and board I/O; port A keeps the existing CPU memory timing.

Parameters:
DATA_W, 16, data word width
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
IO_BASE, 1020, first address of I/O window (port A only); must be < DEPTH
NUM_IO, 4, number of I/O registers at IO_BASE..IO_BASE+NUM_IO-1
CLEAR_ON_RESET, 1, 1 = zero every RAM word after reset; 0 = skip clear

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
a_we  in  1  port A write enable
a_addr  in  ADDR_W  port A address
a_din  in  DATA_W  port A write data
a_dout  out  DATA_W  port A read data, registered
a_stall  out  1  high = port A access ignored this cycle
b_req  in  1  port B request, held until b_ack
b_we  in  1  port B write enable, qualified by b_req
b_addr  in  ADDR_W  port B address
b_din  in  DATA_W  port B write data
b_dout  out  DATA_W  port B read data, valid with b_ack
b_ack  out  1  one-cycle pulse, request completed
io_in  in  NUM_IO*DATA_W  external inputs; slice i at IO_BASE+i
io_out  out  NUM_IO*DATA_W  I/O output registers
ready  out  1  clear finished, memory usable

Behaviour:
- Reset values: a_dout=0, b_dout=0, b_ack=0, io_out=0, clear counter=0. ready=0 and a_stall=1 if CLEAR_ON_RESET, else ready=1 and a_stall=0. RAM contents are not reset.
- FSM states: CLEAR, RUN.
- CLEAR: writes 0 to address cnt each cycle, cnt from 0 to DEPTH-1.
  - Port A is ignored and a_dout holds.
  - b_req is not acknowledged.
  - After writing DEPTH-1, go to RUN next edge: ready=1, a_stall=0.
  - Clear takes exactly DEPTH cycles after reset deassertion.
- Reset asserted mid-clear: restart at cnt=0. Reset in RUN: re-enter CLEAR (if enabled), io_out=0.
- Port A in RUN, RAM address (a_addr outside I/O window):
  - Write: ram[a_addr] <= a_din, and a_dout <= a_din (write-first).
  - Read: a_dout <= ram[a_addr].
  - Latency 1 cycle.
- Port A in RUN, I/O window:
  - Read: a_dout <= io_in slice.
  - Write: io_out slice <= a_din, and a_dout <= a_din. RAM is unaffected.
  - Addresses IO_BASE+NUM_IO..DEPTH-1 remain RAM.
- Port B in RUN:
  - When b_req is high and not blocked, access RAM at b_addr.
  - b_ack pulses the next cycle. On a read, b_dout is valid with b_ack and holds until the next ack.
  - The I/O window is invisible to B: reads return 0, writes are dropped, ack is still given.
  - Back-to-back requests give one ack per cycle; b_req held after ack starts a new access.
- Collision: A write and B access to the same RAM address in the same cycle → A wins.
  - B is blocked that cycle (no ack) and retries automatically while b_req stays high.
  - Same-address reads on both ports never block.
  - A read with B write to the same address: A returns old data, and B's write completes.
- b_req dropped before ack: the request is abandoned with no write.

Decomposition:
- Shared package mem_pkg holds: default DATA_W and ADDR_W, the state encoding (CLEAR, RUN), and the I/O-window compare function.
- One natural sub-module, dp_ram_core: a plain dual-port synchronous array with write-first ports and no reset.
- Clear sequencer, arbitration and I/O decode live in the top level.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=1024 → ready rises exactly 1024 cycles after reset falls. Then A reads addr 0 and 511 → both 0.
- A writes 233 to addr 5, then reads addr 5 → a_dout=233 on the write's cycle+1 and again on the read's cycle+1.
- A writes 0x00AA to 1021; io_in slice 2 = 0x1234 → io_out slice 1 = 0x00AA, A read of 1022 = 0x1234, B read of 1021 = 0 with ack.
- A writes 100 and B writes 60 to addr 7 in the same cycle → b_ack is 2 cycles after the request, final ram[7]=60. A read of addr 8 with a concurrent B read acks in 1 cycle.
- B writes 987 to addr 300, then reads it → b_ack pulses each cycle, b_dout=987. b_req dropped before ack → ram unchanged.
- Reset asserted at cnt=400 during clear → counter restarts, ready rises 1024 cycles after this reset falls, and B gets no ack before then.
